// File: rtl/reg_bank_readback.sv
// reg_bank_readback: walks a bank of 32-bit registers and streams each word
// out over a valid/ready handshake, one FETCH/SEND pair per word.
module reg_bank_readback #(
  parameter int WORDS = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic [WORDS-1:0] rdSel,
  output logic [IDX_W-1:0] rdIndex,
  input  logic [31:0]      rdData,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      outData,
  output logic             outLast,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [1:0] state;
  logic [1:0] stateNext;
  logic       isLast;
  logic       accept;

  assign isLast = (rdIndex == LAST_IDX);
  assign accept = (state == SEND) && outReady;

  // next-state selection
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = FETCH;
      FETCH:   stateNext = SEND;
      SEND: begin
        if (outReady) stateNext = isLast ? DONE : FETCH;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // state register and word index; index never wraps inside a transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rdIndex <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        rdIndex <= '0;
      end else if (accept && !isLast) begin
        rdIndex <= rdIndex + IDX_W'(1);
      end else if (state == DONE) begin
        rdIndex <= '0;
      end
    end
  end

  // capture the bank read bus only while a word is selected
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outData <= '0;
    end else if (state == FETCH) begin
      outData <= rdData;
    end
  end

  // one-hot bank select, decoded from registered state only
  always_comb begin
    rdSel = '0;
    if (state == FETCH) rdSel[rdIndex] = 1'b1;
  end

  // handshake and status flags decoded from state
  always_comb begin
    busy     = (state != IDLE);
    outValid = (state == SEND);
    outLast  = (state == SEND) && isLast;
    done     = (state == DONE);
  end

endmodule

// File: tb/tb_reg_bank_readback.sv
// tb_reg_bank_readback: scoreboard bench for the register bank readback
// sequencer, 4-word instance plus an 8-word parameter check.
module tb_reg_bank_readback;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic          start;
  logic          outReady;
  logic          busy;
  logic          outValid;
  logic          outLast;
  logic          done;
  logic [W-1:0]  rdSel;
  logic [1:0]    rdIndex;
  logic [31:0]   rdData;
  logic [31:0]   outData;
  logic [31:0]   bank [W];

  logic          start8;
  logic          outReady8;
  logic          busy8;
  logic          outValid8;
  logic          outLast8;
  logic          done8;
  logic [7:0]    rdSel8;
  logic [2:0]    rdIndex8;
  logic [31:0]   rdData8;
  logic [31:0]   outData8;
  logic [31:0]   bank8 [8];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  reg_bank_readback #(.WORDS(W), .IDX_W(2)) dut (
    .clk(clk), .reset(rstN), .start(start), .busy(busy),
    .rdSel(rdSel), .rdIndex(rdIndex), .rdData(rdData),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outLast(outLast), .done(done)
  );

  reg_bank_readback #(.WORDS(8), .IDX_W(3)) dut8 (
    .clk(clk), .reset(rstN), .start(start8), .busy(busy8),
    .rdSel(rdSel8), .rdIndex(rdIndex8), .rdData(rdData8),
    .outValid(outValid8), .outReady(outReady8), .outData(outData8),
    .outLast(outLast8), .done(done8)
  );

  // bank model: zero-latency read, garbage when nothing is selected
  always_comb begin
    rdData = 32'hBADC_0DE0 ^ 32'(cyc);
    for (int i = 0; i < W; i++)
      if (rdSel == W'(1 << i)) rdData = bank[i];
  end

  always_comb begin
    rdData8 = 32'h5A5A_0000 ^ 32'(cyc);
    for (int i = 0; i < 8; i++)
      if (rdSel8 == 8'(1 << i)) rdData8 = bank8[i];
  end

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        last;
    logic [1:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   acc[$];
  int   selSeq[$];
  bit   mBusy = 0;
  bit   doneDue = 0;
  int   doneCount = 0;
  int   stallCnt = 0;
  int   startCyc = 0;
  int   doneCyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic failNow(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout", nm);
  endtask

  // monitor: compares every presented word against the expected queue
  always @(negedge clk) begin
    bit clr;
    clr = 0;
    if (rstN) begin
      if (doneDue) begin
        chk("donePulse", 32'(done), 1);
        doneDue = 0;
        doneCount++;
        doneCyc = cyc - startCyc + 1;
        clr = 1;
      end else begin
        chk("noDone", 32'(done), 0);
        if (!mBusy) begin
          chk("idleBusy", 32'(busy), 0);
          chk("idleValid", 32'(outValid), 0);
          chk("idleSel", 32'(rdSel), 0);
        end
      end
      if (rdSel != '0) begin
        selSeq.push_back(int'(rdSel));
        chk("busyFetch", 32'(busy), 1);
        chk("selVsValid", 32'(outValid), 0);
        if (expQ.size() == 0) chk("selNoWord", 32'(rdSel), 0);
        else chk("selOneHot", 32'(rdSel), 32'(1) << expQ[0].idx);
      end
      if (outValid) begin
        chk("busySend", 32'(busy), 1);
        if (expQ.size() == 0) begin
          chk("spuriousValid", 32'(outValid), 0);
        end else begin
          chk("data", outData, expQ[0].data);
          chk("index", 32'(rdIndex), 32'(expQ[0].idx));
          chk("last", 32'(outLast), 32'(expQ[0].last));
          if (outReady) begin
            acc.push_back(cyc - startCyc + 1);
            if (expQ[0].last) doneDue = 1;
            void'(expQ.pop_front());
          end else begin
            stallCnt++;
          end
        end
      end else begin
        chk("lastNoValid", 32'(outLast), 0);
      end
      if (clr) mBusy = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issueStart;
    bit took;
    took = !mBusy;
    start = 1'b1;
    if (took) begin
      for (int i = 0; i < W; i++)
        expQ.push_back(exp_t'{(i == W - 1), 2'(i), bank[i]});
      mBusy = 1;
    end
    tick();
    start = 1'b0;
    if (took) startCyc = cyc;
  endtask

  task automatic waitIdle(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (!mBusy) return;
      tick();
    end
    failNow(nm);
  endtask

  task automatic waitWord(input int k, input string nm);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (outValid && rdIndex == 2'(k)) return;
    end
    failNow(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int n;
    int dRel;
    rstN = 1'b0;
    start = 1'b0;
    start8 = 1'b0;
    outReady = 1'b1;
    outReady8 = 1'b1;
    bank = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    for (int i = 0; i < 8; i++) bank8[i] = 32'h0101_0101 * (i + 1) + 32'h10;
    #3;
    chk("rstBusy", 32'(busy), 0);
    chk("rstSel", 32'(rdSel), 0);
    chk("rstIndex", 32'(rdIndex), 0);
    chk("rstValid", 32'(outValid), 0);
    chk("rstData", outData, 0);
    chk("rstLast", 32'(outLast), 0);
    chk("rstDone", 32'(done), 0);
    chk("rstBusy8", 32'(busy8), 0);
    chk("rstSel8", 32'(rdSel8), 0);
    tick();
    tick();
    rstN = 1'b1;
    tick();

    acc.delete();
    selSeq.delete();
    issueStart();
    waitIdle("basicTimeout");
    chk("basicCount", 32'(acc.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < acc.size()) chk("basicValidCyc", 32'(acc[i]), 32'(2 + 2 * i));
    chk("basicDoneCyc", 32'(doneCyc), 9);
    chk("basicBusyLow", 32'(busy), 0);
    chk("selCount", 32'(selSeq.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < selSeq.size()) chk("selSeq", 32'(selSeq[i]), 32'(1) << i);

    bank[1] = 32'hDEAD_BEEF;
    stallCnt = 0;
    dc = doneCount;
    issueStart();
    waitWord(1, "stallWaitWord1");
    outReady = 1'b0;
    repeat (5) tick();
    outReady = 1'b1;
    waitIdle("stallTimeout");
    chk("stallCycles", 32'(stallCnt), 5);
    chk("stallDone", 32'(doneCount - dc), 1);

    dc = doneCount;
    issueStart();
    waitWord(2, "busyWaitWord2");
    issueStart();
    waitIdle("busyTimeout");
    repeat (4) tick();
    chk("busyStartDones", 32'(doneCount - dc), 1);
    chk("busyStartLeft", 32'(expQ.size()), 0);

    issueStart();
    waitWord(1, "rstWaitWord1");
    outReady = 1'b0;
    tick();
    #2;
    rstN = 1'b0;
    #1;
    chk("midRstBusy", 32'(busy), 0);
    chk("midRstSel", 32'(rdSel), 0);
    chk("midRstIndex", 32'(rdIndex), 0);
    chk("midRstValid", 32'(outValid), 0);
    chk("midRstData", outData, 0);
    chk("midRstLast", 32'(outLast), 0);
    chk("midRstDone", 32'(done), 0);
    expQ.delete();
    mBusy = 0;
    doneDue = 0;
    dc = doneCount;
    tick();
    tick();
    rstN = 1'b1;
    repeat (4) tick();
    chk("midRstNoDone", 32'(doneCount - dc), 0);
    outReady = 1'b1;
    acc.delete();
    issueStart();
    waitIdle("replayTimeout");
    chk("replayCount", 32'(acc.size()), 4);
    chk("replayDone", 32'(doneCount - dc), 1);

    for (int k = 0; k < 600; k++) begin
      outReady = ($urandom_range(0, 3) != 0);
      if (!mBusy)
        for (int i = 0; i < W; i++) bank[i] = $urandom;
      if ($urandom_range(0, 9) == 0) issueStart();
      else tick();
    end
    outReady = 1'b1;
    waitIdle("randDrain");
    chk("randLeft", 32'(expQ.size()), 0);

    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dc = cyc;
    n = 0;
    dRel = 0;
    for (int i = 0; i < 24; i++) begin
      if (rdSel8 != '0)
        chk("sel8", 32'(rdSel8), 32'(1) << n);
      if (outValid8) begin
        if (n < 8) begin
          chk("data8", outData8, bank8[n]);
          chk("last8", 32'(outLast8), 32'(n == 7));
        end
        n++;
      end
      if (done8) dRel = cyc - dc + 1;
      tick();
    end
    chk("count8", 32'(n), 8);
    chk("doneCyc8", 32'(dRel), 17);
    chk("idle8", 32'(busy8), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_readback.md
# reg_bank_readback

Read-side sequencer for a bank of 32-bit registers: on a `start` pulse it walks the bank word by word, drives the one-hot select that gates each register's `outBus` onto a shared read bus, and captures and streams each word out over a valid/ready handshake. It is the counterpart of the decoder-select write path (`regWrite` with a one-hot `decOut1b`). It sits between a cache line's data registers and the write-back/refill consumer.

## Interface
Parameters:
- `WORDS`, 4, number of 32-bit registers in the bank; power of two, at least 2
- `IDX_W`, 2, index width; must equal log2(`WORDS`)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request a full readback; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `rdSel`  out  `WORDS`  one-hot select into the bank; bit i enables register i onto `rdData`
- `rdIndex`  out  `IDX_W`  binary index of the word currently selected or held
- `rdData`  in  32  bank read bus; combinational from the selected register
- `outValid`  out  1  `outData` holds a valid word
- `outReady`  in  1  consumer accepts the word when high together with `outValid`
- `outData`  out  32  captured word
- `outLast`  out  1  high with `outValid` when `rdIndex == WORDS-1`
- `done`  out  1  one-cycle pulse after the last word is accepted

## Operation
- States:
  - IDLE: `busy`=0, `rdSel`=0, `outValid`=0.
  - FETCH: `rdSel` = one-hot(`rdIndex`). At the clock edge, `outData` <= `rdData`.
  - SEND: `outValid`=1 and `rdSel`=0.
  - DONE: `done`=1 for one cycle.
- Transitions:
  - IDLE -> FETCH when `start`=1. `rdIndex` is set to 0.
  - FETCH -> SEND always.
  - SEND -> SEND while `outReady`=0. `outData`, `rdIndex` and `outLast` hold stable.
  - SEND with `outReady`=1 and `rdIndex` < `WORDS-1`: go to FETCH and increment `rdIndex`.
  - SEND with `outReady`=1 and `rdIndex` = `WORDS-1`: go to DONE.
  - DONE -> IDLE always. `rdIndex` returns to 0.
- `start` is ignored in every state except IDLE. It is not queued.
- `rdIndex` never wraps within a transaction. The increment is guarded by the last-word check.
- `rdSel` is registered or decoded from registered state only. It has no combinational path from `outReady` or `start`.
- `outData` is written only in FETCH. In all other states it keeps its last value.
- Reset (`reset`=0, at any time, including mid-transfer):
  - state returns to IDLE; `rdIndex`=0, `outData`=0.
  - `outValid`, `outLast`, `done`, `busy` and `rdSel` are all 0.
  - a transfer cut off by reset produces no `done`.

## Timing
- Reset values: all outputs 0.
- Start to first word: `start` is sampled at edge 0. FETCH occupies cycle 1. `outValid` rises in cycle 2.
- Per word: 2 cycles minimum (FETCH + SEND), plus one cycle for each cycle that `outReady` is low.
- Full transfer with `outReady` held at 1: `2*WORDS` cycles from FETCH of word 0 to the last accept. `done` follows one cycle later.
- A new `start` is accepted no earlier than the cycle after DONE, i.e. while in IDLE.
- A handshake completes on a rising edge where `outValid`=1 and `outReady`=1.
- The consumer may hold `outReady` high continuously, or drive it combinationally from `outValid`.
- `rdData` must be settled within the FETCH cycle. The bank has zero-cycle read latency.

## Test plan
- **Basic readback.** Bank = {0x11111111, 0x22222222, 0x33333333, 0x44444444}, `outReady`=1, one `start` pulse.
  - Required: words 0x11111111..0x44444444 in order, `outValid` in cycles 2, 4, 6, 8.
  - `outLast` only with 0x44444444; `done` in cycle 9; `busy` low from cycle 10.
- **Backpressure.** Hold `outReady`=0 for 5 cycles on word 1 (0xDEADBEEF).
  - Required: `outData`=0xDEADBEEF stable and `outValid`=1 throughout the stall.
  - `rdSel`=0 during the stall; word 2 fetched only after the accept.
- **Start while busy.** Pulse `start` again during word 2.
  - Required: ignored; exactly `WORDS` words and one `done` pulse.
- **Reset mid-transfer.** Assert `reset` low while in SEND of word 1 with `outReady`=0.
  - Required: all outputs 0 immediately (asynchronous); no `done`.
  - A fresh `start` after release replays from word 0.
- **Select check.** Monitor `rdSel` across a transfer.
  - Required: one-hot with bit i only during FETCH of word i (0001, 0010, 0100, 1000); 0 in all other cycles.
- **Parameter sweep.** `WORDS`=8, `IDX_W`=3.
  - Required: 8 words, `outLast` on index 7, `done` 17 cycles after the FETCH of word 0.
